// File: rtl/telem_pkg.sv
// Shared types and constants for the eBike telemetry packet decoder.
// The shadow-load helper maps a payload index onto the 12-bit field it fills.
package telem_pkg;

   typedef enum logic [1:0] {
      HUNT_AA,
      HUNT_55,
      PAYLOAD,
      COMMIT
   } state_t;

   localparam logic [7:0] SYNC0       = 8'hAA;
   localparam logic [7:0] SYNC1       = 8'h55;
   localparam int         PAYLOAD_LEN = 6;

   typedef struct packed {
      logic [11:0] batt;
      logic [11:0] curr;
      logic [11:0] torque;
   } telem_t;

   // Even indices carry the high nibble of a field, odd indices its low byte.
   function automatic telem_t load_shadow(input telem_t s, input logic [2:0] idx,
                                          input logic [7:0] b);
      telem_t r;
      r = s;
      case (idx)
         3'd0:    r.batt[11:8]   = b[3:0];
         3'd1:    r.batt[7:0]    = b;
         3'd2:    r.curr[11:8]   = b[3:0];
         3'd3:    r.curr[7:0]    = b;
         3'd4:    r.torque[11:8] = b[3:0];
         3'd5:    r.torque[7:0]  = b;
         default: r = s;
      endcase
      return r;
   endfunction

endpackage

// File: rtl/telem_decode_tmo.sv
// Inter-byte timeout counter: counts while enabled, zeroed by clear or when disabled.
// An accepted byte (clear) in the expiry cycle suppresses the expire pulse.
module telem_tmo #(
   parameter int TIMEOUT = 100000
) (
   input  logic clk,
   input  logic rst,
   input  logic clear,
   input  logic enable,
   output logic expire
);

   localparam int W = $clog2(TIMEOUT + 1);

   logic [W-1:0] count;

   // Holds at TIMEOUT so a stalled FSM can never wrap the count back to zero.
   always_ff @(posedge clk or posedge rst) begin
      if (rst)
         count <= '0;
      else if (clear || !enable)
         count <= '0;
      else if (count != W'(TIMEOUT))
         count <= count + 1'b1;
   end

   assign expire = enable && !clear && (count == W'(TIMEOUT));

endmodule

// File: rtl/telem_decode.sv
// Frames the 8-byte eBike telemetry packet from UART_rcv bytes and publishes
// batt/curr/torque atomically, with abort handling for bad nibbles and timeouts.
module telem_decode
   import telem_pkg::*;
#(
   parameter int TIMEOUT = 100000
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        rdy,
   input  logic [7:0]  rx_data,
   output logic        clr_rdy,
   output logic [11:0] batt,
   output logic [11:0] curr,
   output logic [11:0] torque,
   output logic        vld,
   output logic        pkt_err,
   output logic [15:0] pkt_cnt,
   output logic [7:0]  err_cnt
);

   state_t     state, state_nxt;
   logic [2:0] idx, idx_nxt;
   telem_t     shadow, shadow_nxt;
   logic       accept;
   logic       abort;
   logic       expire;
   logic       tmo_en;

   // COMMIT refuses bytes so a next-packet 0xAA waits on rdy and lands in HUNT_AA.
   assign accept = rdy && !clr_rdy && (state != COMMIT);
   assign tmo_en = (state == HUNT_55) || (state == PAYLOAD);

   telem_tmo #(.TIMEOUT(TIMEOUT)) u_tmo (
      .clk    (clk),
      .rst    (rst),
      .clear  (accept),
      .enable (tmo_en),
      .expire (expire)
   );

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state  <= HUNT_AA;
         idx    <= '0;
         shadow <= '0;
      end else begin
         state  <= state_nxt;
         idx    <= idx_nxt;
         shadow <= shadow_nxt;
      end
   end

   always_comb begin
      state_nxt  = state;
      idx_nxt    = idx;
      shadow_nxt = shadow;
      abort      = 1'b0;
      case (state)
         HUNT_AA: begin
            if (accept && rx_data == SYNC0)
               state_nxt = HUNT_55;
         end
         HUNT_55: begin
            if (expire) begin
               abort     = 1'b1;
               state_nxt = HUNT_AA;
            end else if (accept) begin
               if (rx_data == SYNC1) begin
                  state_nxt = PAYLOAD;
                  idx_nxt   = '0;
               end else if (rx_data != SYNC0) begin
                  state_nxt = HUNT_AA;
               end
            end
         end
         PAYLOAD: begin
            if (expire) begin
               abort      = 1'b1;
               shadow_nxt = '0;
               state_nxt  = HUNT_AA;
            end else if (accept) begin
               // A bad high byte that is itself 0xAA is treated as the next sync.
               if (!idx[0] && rx_data[7:4] != 4'h0) begin
                  abort      = 1'b1;
                  shadow_nxt = '0;
                  state_nxt  = (rx_data == SYNC0) ? HUNT_55 : HUNT_AA;
               end else begin
                  shadow_nxt = load_shadow(shadow, idx, rx_data);
                  if (idx == 3'(PAYLOAD_LEN - 1))
                     state_nxt = COMMIT;
                  else
                     idx_nxt = idx + 3'd1;
               end
            end
         end
         COMMIT:  state_nxt = HUNT_AA;
         default: state_nxt = HUNT_AA;
      endcase
   end

   // All outputs are registered; the three fields load together from the shadows.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         clr_rdy <= 1'b0;
         vld     <= 1'b0;
         pkt_err <= 1'b0;
         batt    <= '0;
         curr    <= '0;
         torque  <= '0;
         pkt_cnt <= '0;
         err_cnt <= '0;
      end else begin
         clr_rdy <= accept;
         vld     <= (state == COMMIT);
         pkt_err <= abort;
         if (state == COMMIT) begin
            batt    <= shadow.batt;
            curr    <= shadow.curr;
            torque  <= shadow.torque;
            pkt_cnt <= pkt_cnt + 16'd1;
         end
         if (abort && err_cnt != 8'hFF)
            err_cnt <= err_cnt + 8'd1;
      end
   end

endmodule

// File: doc/telem_decode.md
Name: telem_decode

Overview:
- Telemetry packet decoder that sits directly downstream of UART_rcv, on the eBike TX line.
- Consumes received bytes over the rdy/clr_rdy handshake and frames the 8-byte eBike telemetry packet.
- Presents the latest BATT, CURR and TORQUE values with a one-cycle valid pulse, for self-checking benches and telemetry monitors.
- Detects malformed packets and inter-byte timeouts, and resynchronises without a reset.

Parameters:
- TIMEOUT, 100000: maximum clk cycles allowed between accepted bytes inside a packet before the packet is aborted.

Ports:
- clk  in  1  system clock
- rst  in  1  asynchronous, active-high reset
- rdy  in  1  byte available from UART_rcv; held high until cleared
- rx_data  in  8  received byte; stable while rdy is high
- clr_rdy  out  1  one-cycle pulse that consumes the current byte
- batt  out  12  last valid battery reading
- curr  out  12  last valid current reading
- torque  out  12  last valid torque reading
- vld  out  1  one-cycle pulse when batt/curr/torque update
- pkt_err  out  1  one-cycle pulse on packet abort (bad nibble or timeout)
- pkt_cnt  out  16  count of good packets; wraps at 16'hFFFF -> 0
- err_cnt  out  8  count of aborts; saturates at 8'hFF

Behaviour:
- Packet format, byte order: 0xAA, 0x55, {4'h0,batt[11:8]}, batt[7:0], {4'h0,curr[11:8]}, curr[7:0], {4'h0,torque[11:8]}, torque[7:0].
- Acceptance rule: a byte is accepted in a cycle where rdy && !clr_rdy.
  - clr_rdy is registered and asserts the cycle after acceptance, for exactly 1 cycle.
  - The same byte is never consumed twice.
- Reset: all outputs 0, state HUNT_AA, shadow registers 0, timeout counter 0.
- Reset mid-packet discards the partial packet; outputs keep no prior values.
- States:
  - HUNT_AA: on 0xAA -> HUNT_55; any other byte is dropped silently (no pkt_err).
  - HUNT_55: on 0x55 -> PAYLOAD with idx=0. On 0xAA, stay. Any other byte -> HUNT_AA, silently.
  - PAYLOAD: idx 0..5 selects the shadow byte.
    - Even idx (high byte): upper nibble must be 0, else abort.
    - After idx 5 is accepted -> COMMIT.
  - COMMIT: lasts 1 cycle.
    - batt/curr/torque load from the shadows together; no partial update is ever visible.
    - vld=1 and pkt_cnt increments.
    - Then -> HUNT_AA.
- Latency: vld asserts 2 cycles after the cycle in which the final byte is accepted (accept -> COMMIT state -> registered vld). vld and the new data are visible in the same cycle.
- Abort:
  - pkt_err pulses 1 cycle; err_cnt increments, saturating at 255.
  - Shadows are discarded; outputs are unchanged.
  - If the offending byte is 0xAA -> HUNT_55, otherwise -> HUNT_AA.
- Timeout:
  - The counter runs only in HUNT_55 and PAYLOAD, and clears on every accepted byte.
  - When it reaches TIMEOUT -> abort as above, then HUNT_AA.
  - If a byte is accepted in the same cycle the count reaches TIMEOUT, the byte wins: no timeout, counter cleared.
- Back-to-back packets: the 0xAA of the next packet may arrive during COMMIT. It is held by rdy and accepted the next cycle in HUNT_AA; no loss.
- Counters: the widths above are fixed; the timeout counter is $clog2(TIMEOUT+1) bits.

Decomposition:
- telem_pkg:
  - typedef enum for HUNT_AA, HUNT_55, PAYLOAD, COMMIT
  - localparams SYNC0=8'hAA, SYNC1=8'h55, PAYLOAD_LEN=6
  - typedef struct of the three 12-bit fields; the task library compares against this struct
- One natural sub-module: telem_tmo, the timeout counter (clear/enable in, expire pulse out).

Test Plan:
- Single packet AA 55 0B FF 01 23 07 00 -> vld=1 once; batt=12'hBFF, curr=12'h123, torque=12'h700; pkt_cnt=1, err_cnt=0.
- Bad nibble: AA 55 1B … -> pkt_err on the third byte; outputs keep their prior values; the next good packet decodes correctly; err_cnt=1.
- Garbage then resync: 00 AA AA 55 + payload 01 00 00 00 05 00 -> batt=12'h100, torque=12'h500; no pkt_err for the leading junk.
- Timeout: AA 55 0B, then idle TIMEOUT cycles -> pkt_err exactly at TIMEOUT; next packet OK. Byte arriving at TIMEOUT-1 -> no error.
- Back-to-back: 3 packets with rdy held continuously -> 3 vld pulses, pkt_cnt=3, clr_rdy never high 2 cycles in a row.
- Async rst asserted after byte 4 -> all outputs 0 immediately; following full packet decodes with pkt_cnt=1.
